// File: rtl/i2c_sys_pkg.sv
// Shared types and constants for the I2C system slice.
// Wishbone widths, core register map and arbiter state encoding.
package i2c_sys_pkg;

  localparam int WB_ADDR_W = 3;
  localparam int WB_DATA_W = 8;

  localparam logic [WB_ADDR_W-1:0] ADDR_PRER_LO = 3'd0;
  localparam logic [WB_ADDR_W-1:0] ADDR_PRER_HI = 3'd1;
  localparam logic [WB_ADDR_W-1:0] ADDR_CTR     = 3'd2;
  localparam logic [WB_ADDR_W-1:0] ADDR_TXR_RXR = 3'd3;
  localparam logic [WB_ADDR_W-1:0] ADDR_CR_SR   = 3'd4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OWNED   = 2'd1,
    RELEASE = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first pending index after last_i, modulo NREQ.
// Output is one-hot, or zero when nothing is pending.
module rr_pick #(
  parameter int NREQ = 2,
  parameter int LW   = 1
) (
  input  logic [NREQ-1:0] pend_i,
  input  logic [LW-1:0]   last_i,
  output logic [NREQ-1:0] pick_o
);

  logic          found;
  logic [LW-1:0] idx;

  always_comb begin
    pick_o = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = LW'((int'(last_i) + k) % NREQ);
      if (!found && pend_i[idx]) begin
        pick_o[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_wb_arbiter.sv
// Transaction-level Wishbone arbiter in front of the I2C master core.
// Owner keeps the port across accesses via lock; idle watchdog frees it.
module i2c_wb_arbiter
  import i2c_sys_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_cyc,
  input  logic [NREQ-1:0]           req_stb,
  input  logic [NREQ-1:0]           req_we,
  input  logic [WB_ADDR_W*NREQ-1:0] req_addr,
  input  logic [WB_DATA_W*NREQ-1:0] req_wdat,
  input  logic [NREQ-1:0]           req_lock,
  output logic [NREQ-1:0]           req_ack,
  output logic [WB_DATA_W*NREQ-1:0] req_rdat,
  output logic [NREQ-1:0]           req_inta,
  output logic [WB_ADDR_W-1:0]      m_addr,
  output logic [WB_DATA_W-1:0]      m_dat_o,
  output logic                      m_we,
  output logic                      m_stb,
  output logic                      m_cyc,
  input  logic [WB_DATA_W-1:0]      m_dat_i,
  input  logic                      m_ack,
  input  logic                      m_inta,
  output logic [NREQ-1:0]           grant,
  output logic                      busy,
  output logic                      timeout_err
);

  localparam int LW = (NREQ > 2) ? 2 : 1;

  arb_state_e      state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [NREQ-1:0] stale_q, stale_d;
  logic [LW-1:0]   last_q, last_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            terr_q, terr_d;

  logic [NREQ-1:0] lock_eff;
  logic [NREQ-1:0] pend;
  logic [NREQ-1:0] pick;
  logic [LW-1:0]   own;
  logic            own_cyc;
  logic            own_lock;

  // A lock that timed out is ignored until its owner lets go of it.
  assign lock_eff = req_lock & ~stale_q;
  assign pend     = req_cyc | lock_eff;

  rr_pick #(
    .NREQ (NREQ),
    .LW   (LW)
  ) u_pick (
    .pend_i (pend),
    .last_i (last_q),
    .pick_o (pick)
  );

  always_comb begin
    own      = '0;
    own_cyc  = 1'b0;
    own_lock = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_q[i]) begin
        own      = LW'(i);
        own_cyc  = req_cyc[i];
        own_lock = lock_eff[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    terr_d  = 1'b0;
    stale_d = stale_q & req_lock;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (|pend) begin
          grant_d = pick;
          state_d = OWNED;
        end
      end
      OWNED: begin
        if (own_cyc) begin
          cnt_d = '0;
        end else if (!own_lock) begin
          last_d  = own;
          grant_d = '0;
          cnt_d   = '0;
          state_d = RELEASE;
        end else begin
          if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
          if (cnt_d >= 8'(TIMEOUT)) begin
            terr_d  = 1'b1;
            last_d  = own;
            stale_d = stale_d | grant_q;
            grant_d = '0;
            cnt_d   = '0;
            state_d = RELEASE;
          end
        end
      end
      RELEASE: begin
        state_d = IDLE;
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      stale_q <= '0;
      last_q  <= LW'(NREQ - 1);
      cnt_q   <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      stale_q <= stale_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      terr_q  <= terr_d;
    end
  end

  always_comb begin
    m_cyc    = 1'b0;
    m_stb    = 1'b0;
    m_we     = 1'b0;
    m_addr   = '0;
    m_dat_o  = '0;
    req_ack  = '0;
    req_rdat = '0;
    req_inta = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_q[i]) begin
        m_cyc = req_cyc[i];
        m_stb = req_stb[i] & req_cyc[i];
        if (req_cyc[i]) begin
          m_we    = req_we[i];
          m_addr  = req_addr[WB_ADDR_W*i +: WB_ADDR_W];
          m_dat_o = req_wdat[WB_DATA_W*i +: WB_DATA_W];
        end
        req_ack[i] = m_ack & req_cyc[i];
        req_rdat[WB_DATA_W*i +: WB_DATA_W] = m_dat_i;
        req_inta[i] = m_inta;
      end
    end
  end

  assign grant       = grant_q;
  assign busy        = |grant_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_i2c_wb_arbiter.sv
// Self-checking bench for i2c_wb_arbiter (NREQ=2, TIMEOUT=4).
// Vector table, directed corner sequences and random traffic vs a model.
module tb_i2c_wb_arbiter;

  localparam int N   = 2;
  localparam int TMO = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  cyc = '0;
  logic [N-1:0]  stb = '0;
  logic [N-1:0]  we = '0;
  logic [N-1:0]  lock = '0;
  logic [3*N-1:0] addr = '0;
  logic [8*N-1:0] wdat = '0;
  logic [7:0]    m_dat_i = '0;
  logic          m_ack = 1'b0;
  logic          m_inta = 1'b0;

  logic [N-1:0]   req_ack;
  logic [8*N-1:0] req_rdat;
  logic [N-1:0]   req_inta;
  logic [2:0]     m_addr;
  logic [7:0]     m_dat_o;
  logic           m_we;
  logic           m_stb;
  logic           m_cyc;
  logic [N-1:0]   grant;
  logic           busy;
  logic           timeout_err;

  int checks = 0;
  int errors = 0;

  // Reference: owner index (-1 = none), release gap, fairness pointer.
  int     mo = -1;
  bit     mrel = 1'b0;
  int     mlast = N - 1;
  int     midle = 0;
  bit [N-1:0] mstale = '0;
  bit     mterr = 1'b0;

  i2c_wb_arbiter #(
    .NREQ    (N),
    .TIMEOUT (TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_cyc     (cyc),
    .req_stb     (stb),
    .req_we      (we),
    .req_addr    (addr),
    .req_wdat    (wdat),
    .req_lock    (lock),
    .req_ack     (req_ack),
    .req_rdat    (req_rdat),
    .req_inta    (req_inta),
    .m_addr      (m_addr),
    .m_dat_o     (m_dat_o),
    .m_we        (m_we),
    .m_stb       (m_stb),
    .m_cyc       (m_cyc),
    .m_dat_i     (m_dat_i),
    .m_ack       (m_ack),
    .m_inta      (m_inta),
    .grant       (grant),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  cyc, stb, we, lock;
    logic [2:0]  a0, a1;
    logic [7:0]  d0, d1, mdi;
    logic        mack, minta;
    logic [1:0]  egrant;
    logic        ecyc;
    logic [2:0]  eaddr;
    logic [7:0]  edat;
    logic [1:0]  eack;
    logic [15:0] erdat;
    logic [1:0]  einta;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mo = -1; mrel = 1'b0; mlast = N - 1;
    midle = 0; mstale = '0; mterr = 1'b0;
  endtask

  task automatic model_step();
    bit [N-1:0] ns;
    bit nterr;
    int j;
    nterr = 1'b0;
    ns = mstale & lock;
    if (mo >= 0) begin
      if (cyc[mo]) begin
        midle = 0;
      end else if (!(lock[mo] && !mstale[mo])) begin
        mlast = mo; mo = -1; mrel = 1'b1; midle = 0;
      end else begin
        midle = (midle < 255) ? midle + 1 : 255;
        if (midle >= TMO) begin
          nterr = 1'b1; ns[mo] = 1'b1;
          mlast = mo; mo = -1; mrel = 1'b1; midle = 0;
        end
      end
    end else if (mrel) begin
      mrel = 1'b0;
    end else begin
      for (int k = 1; k <= N; k++) begin
        j = (mlast + k) % N;
        if (mo < 0 && (cyc[j] || (lock[j] && !mstale[j]))) mo = j;
      end
    end
    mstale = ns;
    mterr = nterr;
  endtask

  task automatic check_model();
    logic ecyc, estb, ewe;
    logic [2:0] ea;
    logic [7:0] ed;
    logic [N-1:0] eack, einta, egr;
    logic [8*N-1:0] erd;
    ecyc = 0; estb = 0; ewe = 0; ea = 0; ed = 0;
    eack = 0; einta = 0; egr = 0; erd = 0;
    if (mo >= 0) begin
      egr[mo] = 1'b1;
      if (cyc[mo]) begin
        ecyc = 1'b1;
        estb = stb[mo];
        ewe  = we[mo];
        ea   = addr[3*mo +: 3];
        ed   = wdat[8*mo +: 8];
        eack[mo] = m_ack;
      end
      erd[8*mo +: 8] = m_dat_i;
      einta[mo] = m_inta;
    end
    chk("m_grant", 32'(grant), 32'(egr));
    chk("m_busy", 32'(busy), 32'(mo >= 0));
    chk("m_terr", 32'(timeout_err), 32'(mterr));
    chk("m_cyc", 32'(m_cyc), 32'(ecyc));
    chk("m_stb", 32'(m_stb), 32'(estb));
    chk("m_we", 32'(m_we), 32'(ewe));
    chk("m_addr", 32'(m_addr), 32'(ea));
    chk("m_dat_o", 32'(m_dat_o), 32'(ed));
    chk("m_ack", 32'(req_ack), 32'(eack));
    chk("m_rdat", 32'(req_rdat), 32'(erd));
    chk("m_inta", 32'(req_inta), 32'(einta));
  endtask

  task automatic at_neg();
    @(negedge clk);
    check_model();
  endtask

  task automatic at_pos();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic step();
    at_neg();
    at_pos();
  endtask

  task automatic idle_in();
    cyc = '0; stb = '0; we = '0; m_ack = 1'b0;
  endtask

  initial begin
    // cyc stb we lock a0 a1 d0 d1 mdi mack minta | grant cyc addr dat ack rdat inta
    tbl[0]  = '{2'b01, 2'b01, 2'b01, 2'b01, 3'd0, 3'd0, 8'hC8, 8'h00, 8'h00, 1'b0, 1'b0,
                2'b00, 1'b0, 3'd0, 8'h00, 2'b00, 16'h0000, 2'b00};
    tbl[1]  = '{2'b01, 2'b01, 2'b01, 2'b01, 3'd0, 3'd0, 8'hC8, 8'h00, 8'h00, 1'b0, 1'b0,
                2'b01, 1'b1, 3'd0, 8'hC8, 2'b00, 16'h0000, 2'b00};
    tbl[2]  = '{2'b01, 2'b01, 2'b01, 2'b01, 3'd0, 3'd0, 8'hC8, 8'h00, 8'h00, 1'b1, 1'b0,
                2'b01, 1'b1, 3'd0, 8'hC8, 2'b01, 16'h0000, 2'b00};
    tbl[3]  = '{2'b00, 2'b00, 2'b00, 2'b01, 3'd0, 3'd0, 8'hC8, 8'h00, 8'h00, 1'b0, 1'b0,
                2'b01, 1'b0, 3'd0, 8'h00, 2'b00, 16'h0000, 2'b00};
    tbl[4]  = '{2'b00, 2'b00, 2'b00, 2'b00, 3'd0, 3'd0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0,
                2'b01, 1'b0, 3'd0, 8'h00, 2'b00, 16'h0000, 2'b00};
    tbl[5]  = '{2'b00, 2'b00, 2'b00, 2'b00, 3'd0, 3'd0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0,
                2'b00, 1'b0, 3'd0, 8'h00, 2'b00, 16'h0000, 2'b00};
    tbl[6]  = '{2'b00, 2'b00, 2'b00, 2'b00, 3'd0, 3'd0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0,
                2'b00, 1'b0, 3'd0, 8'h00, 2'b00, 16'h0000, 2'b00};
    tbl[7]  = '{2'b10, 2'b10, 2'b00, 2'b10, 3'd0, 3'd4, 8'h00, 8'h00, 8'hA5, 1'b0, 1'b1,
                2'b00, 1'b0, 3'd0, 8'h00, 2'b00, 16'h0000, 2'b00};
    tbl[8]  = '{2'b10, 2'b10, 2'b00, 2'b10, 3'd0, 3'd4, 8'h00, 8'h00, 8'hA5, 1'b1, 1'b1,
                2'b10, 1'b1, 3'd4, 8'h00, 2'b10, 16'hA500, 2'b10};
    tbl[9]  = '{2'b00, 2'b00, 2'b00, 2'b00, 3'd0, 3'd4, 8'h00, 8'h00, 8'hA5, 1'b0, 1'b1,
                2'b10, 1'b0, 3'd0, 8'h00, 2'b00, 16'hA500, 2'b10};
    tbl[10] = '{2'b00, 2'b00, 2'b00, 2'b00, 3'd0, 3'd4, 8'h00, 8'h00, 8'hA5, 1'b1, 1'b1,
                2'b00, 1'b0, 3'd0, 8'h00, 2'b00, 16'h0000, 2'b00};
    tbl[11] = '{2'b00, 2'b00, 2'b00, 2'b00, 3'd0, 3'd0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0,
                2'b00, 1'b0, 3'd0, 8'h00, 2'b00, 16'h0000, 2'b00};

    // Reset state, with live core-side inputs that must not leak.
    m_ack = 1'b1; m_inta = 1'b1; m_dat_i = 8'hFF;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_grant", 32'(grant), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_terr", 32'(timeout_err), 0);
    chk("rst_mcyc", 32'(m_cyc), 0);
    chk("rst_ack", 32'(req_ack), 0);
    chk("rst_rdat", 32'(req_rdat), 0);
    chk("rst_inta", 32'(req_inta), 0);
    rst = 1'b0;
    m_ack = 1'b0; m_inta = 1'b0; m_dat_i = '0;
    model_reset();

    for (int r = 0; r < 12; r++) begin
      cyc = tbl[r].cyc; stb = tbl[r].stb; we = tbl[r].we; lock = tbl[r].lock;
      addr = {tbl[r].a1, tbl[r].a0}; wdat = {tbl[r].d1, tbl[r].d0};
      m_dat_i = tbl[r].mdi; m_ack = tbl[r].mack; m_inta = tbl[r].minta;
      at_neg();
      chk($sformatf("v%0d_grant", r), 32'(grant), 32'(tbl[r].egrant));
      chk($sformatf("v%0d_mcyc", r), 32'(m_cyc), 32'(tbl[r].ecyc));
      chk($sformatf("v%0d_maddr", r), 32'(m_addr), 32'(tbl[r].eaddr));
      chk($sformatf("v%0d_mdat", r), 32'(m_dat_o), 32'(tbl[r].edat));
      chk($sformatf("v%0d_ack", r), 32'(req_ack), 32'(tbl[r].eack));
      chk($sformatf("v%0d_rdat", r), 32'(req_rdat), 32'(tbl[r].erdat));
      chk($sformatf("v%0d_inta", r), 32'(req_inta), 32'(tbl[r].einta));
      at_pos();
    end

    // Simultaneous requests and rotation.
    m_dat_i = '0; m_inta = 1'b0; lock = '0;
    cyc = 2'b11; stb = 2'b11; m_ack = 1'b0;
    step();
    chk("sim_first", 32'(grant), 32'(2'b01));
    cyc = 2'b10; stb = 2'b10;
    step(); step(); step();
    chk("sim_second", 32'(grant), 32'(2'b10));
    idle_in();
    step(); step(); step();
    cyc = 2'b11; stb = 2'b11;
    step();
    chk("sim_rotate", 32'(grant), 32'(2'b01));

    // req0 keeps the port locked across six accesses; req1 waits.
    lock = 2'b01;
    addr = {3'd3, 3'd1}; wdat[15:8] = 8'h5A;
    for (int a = 0; a < 6; a++) begin
      cyc = 2'b11; stb = 2'b11; we = 2'b11; wdat[7:0] = 8'(a); m_ack = 1'b1;
      at_neg();
      chk("lock_ack1", 32'(req_ack[1]), 0);
      chk("lock_mdat", 32'(m_dat_o), 32'(a));
      at_pos();
      cyc = 2'b10; stb = 2'b10; m_ack = 1'b0;
      step();
      chk("lock_grant", 32'(grant), 32'(2'b01));
    end
    lock = 2'b00;
    step();
    chk("handoff_gap1", 32'(grant), 0);
    step();
    chk("handoff_gap2", 32'(grant), 0);
    step();
    chk("handoff_req1", 32'(grant), 32'(2'b10));
    idle_in();
    step(); step(); step();

    // Watchdog: req0 sits on its lock with no access.
    cyc = 2'b01; stb = 2'b01; lock = 2'b01; m_ack = 1'b1;
    step();
    chk("wd_grant", 32'(grant), 32'(2'b01));
    step();
    cyc = 2'b10; stb = 2'b10; m_ack = 1'b0;
    for (int k = 1; k <= TMO; k++) begin
      step();
      chk($sformatf("wd_terr%0d", k), 32'(timeout_err), 32'(k == TMO));
    end
    chk("wd_released", 32'(grant), 0);
    step();
    chk("wd_pulse_end", 32'(timeout_err), 0);
    step();
    chk("wd_req1", 32'(grant), 32'(2'b10));
    idle_in();
    step(); step();
    for (int k = 0; k < 5; k++) begin
      step();
      chk("wd_stale", 32'(grant), 0);
    end
    lock = 2'b00;
    step();
    lock = 2'b01;
    step();
    chk("wd_relock", 32'(grant), 32'(2'b01));
    lock = 2'b00;
    step(); step(); step();

    // Random traffic against the reference.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        cyc[i] = ($urandom_range(99) < 35);
        stb[i] = cyc[i] & ($urandom_range(3) != 0);
        if ($urandom_range(9) == 0) lock[i] = ~lock[i];
      end
      we = N'($urandom);
      addr = (3*N)'($urandom);
      wdat = (8*N)'($urandom);
      m_ack = 1'($urandom);
      m_inta = 1'($urandom);
      m_dat_i = 8'($urandom);
      step();
    end

    // Reset in the middle of an access.
    lock = '0; cyc = 2'b01; stb = 2'b01;
    m_ack = 1'b1; m_inta = 1'b1; m_dat_i = 8'hFF;
    for (int k = 0; k < 8 && m_cyc !== 1'b1; k++) step();
    chk("rst_mid_setup", 32'(m_cyc), 1);
    rst = 1'b1;
    #1;
    chk("rstm_mcyc", 32'(m_cyc), 0);
    chk("rstm_mstb", 32'(m_stb), 0);
    chk("rstm_maddr", 32'(m_addr), 0);
    chk("rstm_mdat", 32'(m_dat_o), 0);
    chk("rstm_ack", 32'(req_ack), 0);
    chk("rstm_rdat", 32'(req_rdat), 0);
    chk("rstm_inta", 32'(req_inta), 0);
    chk("rstm_grant", 32'(grant), 0);
    chk("rstm_busy", 32'(busy), 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 2'b11; stb = 2'b11; m_ack = 1'b0;
    step();
    chk("rst_first_req0", 32'(grant), 32'(2'b01));
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_wb_arbiter.md
Name: i2c_wb_arbiter

Overview:
- Shares the single Wishbone slave port of the I2C master core between NREQ requesters, e.g. two i2c_sys_top-style sequencers in different security domains.
- Grants whole I2C transactions, not single accesses: a requester holds ownership across its PRER/CTR/TXR/CR/SR/RXR access sequence with req_lock.
- Round-robin fairness between requesters.
- Read data, ack and interrupt go only to the owner; non-owners see zeros.

Parameters:
NREQ, 2, number of requesters (2..4)
TIMEOUT, 255, idle cycles an owner may hold the lock with no access before forced release (1..255)

Ports:
clk  in  1  clock
rst  in  1  reset
req_cyc  in  NREQ  per-requester WB cyc
req_stb  in  NREQ  per-requester WB stb
req_we  in  NREQ  per-requester WB we
req_addr  in  3*NREQ  packed register address, requester i at [3i+2:3i]
req_wdat  in  8*NREQ  packed write data
req_lock  in  NREQ  hold ownership between accesses
req_ack  out  NREQ  ack, owner only
req_rdat  out  8*NREQ  read data, owner lane only, others 0
req_inta  out  NREQ  core interrupt, owner only
m_addr  out  3  to core
m_dat_o  out  8  to core
m_we  out  1  to core
m_stb  out  1  to core
m_cyc  out  1  to core
m_dat_i  in  8  from core
m_ack  in  1  from core
m_inta  in  1  from core
grant  out  NREQ  one-hot owner, registered
busy  out  1  grant != 0
timeout_err  out  1  one-cycle pulse on forced release

Behaviour:
- Reset is asynchronous, active-high, on rst; clock is clk.
- Reset values: state IDLE, grant 0, last_owner NREQ-1 (so requester 0 has first priority), idle counter 0, timeout_err 0. All m_* and req_* outputs are 0.
- States: IDLE, OWNED, RELEASE.
- IDLE:
  - A requester is pending when req_cyc[i] | req_lock[i].
  - If any requester is pending, pick the first pending index scanning last_owner+1, +2, ... modulo NREQ.
  - Register grant, go to OWNED.
  - Latency: request at cycle N -> grant at N+1 -> m_cyc earliest at N+1.
- OWNED, forwarding (combinational from the owner o):
  - m_cyc = req_cyc[o]; m_stb = req_stb[o] & req_cyc[o].
  - m_we, m_addr, m_dat_o come from lane o, gated to 0 when m_cyc = 0.
  - req_ack[o] = m_ack & m_cyc; req_rdat lane o = m_dat_i; req_inta[o] = m_inta.
  - All other lanes are 0 (no cross-domain leakage).
- OWNED, release:
  - When req_cyc[o] = 0 and req_lock[o] = 0: last_owner <= o, grant <= 0, go to RELEASE.
- OWNED, watchdog:
  - The idle counter increments each cycle with req_cyc[o] = 0 and req_lock[o] = 1, and clears on req_cyc[o].
  - Reaching TIMEOUT forces release: timeout_err = 1 for one cycle, last_owner <= o, go to RELEASE.
  - Lock stays ignored for o until o deasserts req_lock for at least one cycle (per-requester stale flag; it clears only when req_lock[i] = 0).
- RELEASE: lasts exactly one cycle.
  - m_* are 0 and any m_ack is discarded.
  - Go to IDLE. Arbitration happens in IDLE on the next cycle, so ownership changes need at least 2 cycles with no core access.
- Abort: if the owner drops req_cyc mid-access before m_ack, m_cyc drops the same cycle. A late m_ack is not forwarded.
- Simultaneous events:
  - Owner release and another requester pending in the same cycle: normal RELEASE then IDLE arbitration; the new owner is chosen by round-robin.
  - Watchdog expiry coincident with an owner cyc: the access wins and the counter clears.
- Reset mid-access: outputs drop to 0 asynchronously and grant is cleared. Requesters must restart their transactions.
- Widths: idle counter is 8 bits and saturates.

Decomposition:
- Shared package i2c_sys_pkg holds:
  - Arbiter state encoding (IDLE = 2'd0, OWNED = 2'd1, RELEASE = 2'd2).
  - Core register address constants (PRER_LO 0, PRER_HI 1, CTR 2, TXR/RXR 3, CR/SR 4).
  - WB_ADDR_W = 3 and WB_DATA_W = 8.
- One sub-module, rr_pick: combinational round-robin picker (inputs pending vector and last_owner; output one-hot pick).

Test Plan:
- Single requester: req0 writes PRER_LO = 0xC8 with lock held, then releases -> grant 01 one cycle after req_cyc; m_addr 0, m_dat_o 0xC8; req_ack[0] mirrors m_ack; grant 00 after release.
- Simultaneous: req0 and req1 assert cyc on the same cycle after reset -> req0 granted first; after its release req1 is granted; on the next simultaneous request req0 wins again (rotation).
- Lock: req0 locked across 6 accesses while req1 continuously requests -> req1 never sees ack, m_* never show req1 values; req1 is granted 2 cycles after req0 drops lock and cyc.
- Isolation: req1 owner reads SR with m_dat_i = 0xA5 and m_inta = 1 -> req_rdat lane1 = 0xA5, lane0 = 0x00, req_inta = 10.
- Watchdog: TIMEOUT = 4, req0 holds lock with no cyc -> timeout_err pulses 4 cycles after the last access; req1 granted next; req0 is not re-granted until it toggles lock low.
- Reset mid-access: assert rst while m_cyc = 1 -> all outputs 0 immediately; after rst drops, the next grant goes to req0.
